// File: rtl/mcc_pkg.sv
// Shared definitions for the multiplier console controller.
//   state_e        : controller state encoding, as seen on state_o
//   K_MODE..K_AUTO : bit positions inside the active-low key vector
//   BANNER_DEFAULT : banner word shown in the BANNER state (resized by the top)
package mcc_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StBanner   = 3'd1,
        StEdit     = 3'd2,
        StCalc     = 3'd3,
        StResult   = 3'd4,
        StAutoOps  = 3'd5,
        StAutoMul  = 3'd6,
        StAutoProd = 3'd7
    } state_e;

    localparam int unsigned NumKeys = 5;
    localparam int unsigned K_MODE  = 0;
    localparam int unsigned K_INC_A = 1;
    localparam int unsigned K_INC_B = 2;
    localparam int unsigned K_EVAL  = 3;
    localparam int unsigned K_AUTO  = 4;

    localparam logic [23:0] BANNER_DEFAULT = 24'h332002;

endpackage

// File: rtl/mult_console_ctrl_if.sv
// Console bundle between the key/tick source and the controller.
//   tick      : one-cycle dwell enable
//   key_n     : debounced active-low keys (see K_* in mcc_pkg)
//   disp_word : 3*W-bit hex word for the seven-segment scanner
//   led_en    : LED chaser enable
//   state_o   : current controller state
//   busy      : multiplier running
// master = stimulus/board side, slave = controller side.
interface mult_console_ctrl_if #(
    parameter int unsigned W = 8
);
    logic           tick;
    logic [4:0]     key_n;
    logic [3*W-1:0] disp_word;
    logic           led_en;
    logic [2:0]     state_o;
    logic           busy;

    modport master (
        output tick, key_n,
        input  disp_word, led_en, state_o, busy
    );

    modport slave (
        input  tick, key_n,
        output disp_word, led_en, state_o, busy
    );
endinterface

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst  : clock, synchronous active-high reset (aborts a running multiply)
//   start_i   : one-cycle pulse; samples a_i/b_i, restarts even if busy
//   a_i, b_i  : W-bit operands
//   busy_o    : high for the W cycles after start
//   done_o    : one-cycle pulse W+1 cycles after start; product_o valid then
//   product_o : 2*W-bit product
module seq_mult #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int unsigned CntW = $clog2(W + 1);

    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start_i) begin
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = CntW'(W);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            // Last partial product lands this edge; done follows in the next cycle.
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/mult_console_ctrl.sv
// Key-driven multiplier console: banner, operand edit, single multiply and
// (optionally) an auto-sweep that steps two operands and shows their product.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mult_console_ctrl_if.slave (tick, key_n in; disp_word, led_en,
//              state_o, busy out)
// Build option: define MCC_AUTO_EN to include the auto-sweep states, the auto
// operands and the dwell counter; otherwise auto and eval-in-RESULT are ignored.
module mult_console_ctrl
    import mcc_pkg::*;
#(
    parameter int unsigned      W       = 8,
    parameter logic [3*W-1:0]   BANNER  = (3*W)'(BANNER_DEFAULT),
    parameter logic [W-1:0]     AUTO_A0 = W'(1),
    parameter logic [W-1:0]     AUTO_B0 = W'(2),
    parameter int unsigned      DWELL   = 1
) (
    input logic               clk,
    input logic               rst,
    mult_console_ctrl_if.slave bus
);
`ifdef MCC_AUTO_EN
    localparam bit AutoEn = 1'b1;
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
`else
    localparam bit AutoEn = 1'b0;
`endif

    logic [NumKeys-1:0] key_q, key_prev_q, held_q, press;
    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic [W-1:0]       op_a, op_b;
    logic               mult_start, mult_busy, mult_done;
    logic [2*W-1:0]     mult_prod;
    logic               p_mode, p_eval, p_inc;
    logic [3*W-1:0]     disp;

`ifdef MCC_AUTO_EN
    logic               p_auto;
    logic [W-1:0]       aa_q, aa_d, ab_q, ab_d;
    logic [2*W-1:0]     aprod_q, aprod_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
`endif

    // held_q masks keys already down at reset so their release-free level
    // after reset is not mistaken for a fresh falling edge.
    assign press = key_prev_q & ~key_q & ~held_q;

    // Priority: mode > eval > auto > inc (inc_a/inc_b share one class).
    assign p_mode = press[K_MODE];
    assign p_eval = press[K_EVAL] & ~press[K_MODE];
    assign p_inc  = (press[K_INC_A] | press[K_INC_B]) & ~press[K_MODE] & ~press[K_EVAL]
                    & ~(AutoEn & press[K_AUTO]);
`ifdef MCC_AUTO_EN
    assign p_auto = press[K_AUTO] & ~press[K_MODE] & ~press[K_EVAL];
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        mult_start = 1'b0;
        op_a       = a_q;
        op_b       = b_q;
`ifdef MCC_AUTO_EN
        aa_d    = aa_q;
        ab_d    = ab_q;
        aprod_d = aprod_q;
        cnt_d   = cnt_q;
        if (state_q == StAutoOps) begin
            op_a = aa_q;
            op_b = ab_q;
        end
`endif
        unique case (state_q)
            StIdle: begin
                if (p_mode) state_d = StBanner;
            end
            StBanner: begin
                if (p_mode) state_d = StIdle;
`ifdef MCC_AUTO_EN
                else if (p_auto) begin
                    state_d = StAutoOps;
                    aa_d    = AUTO_A0;
                    ab_d    = AUTO_B0;
                end
`endif
                else if (p_inc) state_d = StEdit;
            end
            StEdit: begin
                if (p_mode) state_d = StIdle;
                else if (p_eval) begin
                    mult_start = 1'b1;
                    state_d    = StCalc;
                end
`ifdef MCC_AUTO_EN
                else if (p_auto) begin
                    state_d = StAutoOps;
                    aa_d    = AUTO_A0;
                    ab_d    = AUTO_B0;
                end
`endif
                else if (p_inc) begin
                    a_d = a_q + W'(press[K_INC_A]);
                    b_d = b_q + W'(press[K_INC_B]);
                end
            end
            StCalc: begin
                if (mult_done) begin
                    prod_d  = mult_prod;
                    state_d = StResult;
                end
            end
            StResult: begin
                if (p_mode) state_d = StIdle;
`ifdef MCC_AUTO_EN
                else if (p_eval) state_d = StAutoOps;
                else if (p_auto) begin
                    state_d = StAutoOps;
                    aa_d    = AUTO_A0;
                    ab_d    = AUTO_B0;
                end
`endif
                else if (p_inc) begin
                    a_d     = a_q + W'(press[K_INC_A]);
                    b_d     = b_q + W'(press[K_INC_B]);
                    state_d = StEdit;
                end
            end
`ifdef MCC_AUTO_EN
            StAutoOps: begin
                if (p_mode) state_d = StIdle;
                else if (p_auto) state_d = StBanner;
                else if (bus.tick) begin
                    if (cnt_q == CntW'(DWELL - 1)) begin
                        mult_start = 1'b1;
                        state_d    = StAutoMul;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StAutoMul: begin
                if (p_mode) state_d = StIdle;
                else if (p_auto) state_d = StBanner;
                else if (mult_done) begin
                    aprod_d = mult_prod;
                    state_d = StAutoProd;
                end
            end
            StAutoProd: begin
                if (p_mode) state_d = StIdle;
                else if (p_auto) state_d = StBanner;
                else if (bus.tick) begin
                    if (cnt_q == CntW'(DWELL - 1)) begin
                        aa_d    = aa_q + 1'b1;
                        ab_d    = ab_q + 1'b1;
                        state_d = StAutoOps;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
`ifdef MCC_AUTO_EN
        if (state_d != state_q) cnt_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= '1;
            key_prev_q <= '1;
            held_q     <= ~bus.key_n;
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
        end else begin
            key_q      <= bus.key_n;
            key_prev_q <= key_q;
            held_q     <= held_q & ~bus.key_n;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            prod_q     <= prod_d;
        end
    end

`ifdef MCC_AUTO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            aa_q    <= AUTO_A0;
            ab_q    <= AUTO_B0;
            aprod_q <= '0;
            cnt_q   <= '0;
        end else begin
            aa_q    <= aa_d;
            ab_q    <= ab_d;
            aprod_q <= aprod_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    seq_mult #(
        .W (W)
    ) u_seq_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mult_start),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mult_busy),
        .done_o    (mult_done),
        .product_o (mult_prod)
    );

    always_comb begin
        disp = '0;
        unique case (state_q)
            StBanner:          disp = BANNER;
            StEdit:            disp = {a_q, b_q, {W{1'b0}}};
            StCalc, StResult:  disp = {{W{1'b0}}, prod_q};
`ifdef MCC_AUTO_EN
            StAutoOps, StAutoMul: disp = {aa_q, ab_q, {W{1'b0}}};
            StAutoProd:           disp = {{W{1'b0}}, aprod_q};
`endif
            default:           disp = '0;
        endcase
    end

    assign bus.disp_word = disp;
    assign bus.led_en    = (state_q == StBanner);
    assign bus.state_o   = state_q;
    assign bus.busy      = mult_busy;

endmodule

// File: tb/tb_mult_console_ctrl.sv
// Self-checking bench for mult_console_ctrl: directed timing cases plus a
// randomized key/tick walk compared against a behavioural console model.
module tb_mult_console_ctrl;
    import mcc_pkg::*;

    localparam int unsigned    W     = 8;
    localparam int unsigned    DWELL = 1;
    localparam logic [W-1:0]   A0    = 8'h01;
    localparam logic [W-1:0]   B0    = 8'h02;
    localparam logic [3*W-1:0] BAN   = 24'h332002;
`ifdef MCC_AUTO_EN
    localparam bit AutoEn = 1'b1;
`else
    localparam bit AutoEn = 1'b0;
`endif

    localparam logic [4:0] KMode = 5'b00001;
    localparam logic [4:0] KIncA = 5'b00010;
    localparam logic [4:0] KIncB = 5'b00100;
    localparam logic [4:0] KEval = 5'b01000;
    localparam logic [4:0] KAuto = 5'b10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_console_ctrl_if #(.W(W)) bus();

    mult_console_ctrl #(
        .W       (W),
        .BANNER  (BAN),
        .AUTO_A0 (A0),
        .AUTO_B0 (B0),
        .DWELL   (DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: state named by the spec's numbering, plain arithmetic.
    state_e         m_state;
    logic [W-1:0]   m_a, m_b, m_aa, m_ab;
    logic [2*W-1:0] m_prod, m_aprod;
    int             m_cnt;

    function automatic logic [2*W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return (2*W)'(p);
    endfunction

    function automatic logic [3*W-1:0] exp_disp();
        case (m_state)
            StBanner:             return BAN;
            StEdit:               return {m_a, m_b, 8'h00};
            StCalc, StResult:     return {8'h00, m_prod};
            StAutoOps, StAutoMul: return {m_aa, m_ab, 8'h00};
            StAutoProd:           return {8'h00, m_aprod};
            default:              return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = StIdle;
        m_a = '0; m_b = '0; m_aa = A0; m_ab = B0;
        m_prod = '0; m_aprod = '0; m_cnt = 0;
    endtask

    task automatic model_press(input logic [4:0] mask);
        state_e prev;
        prev = m_state;
        if (m_state == StCalc) return;
        if (mask[K_MODE]) begin
            m_state = (m_state == StIdle) ? StBanner : StIdle;
        end else if (mask[K_EVAL]) begin
            if (m_state == StEdit) begin
                m_prod  = mul(m_a, m_b);
                m_state = StResult;
            end else if (m_state == StResult && AutoEn) begin
                m_state = StAutoOps;
            end
        end else if (AutoEn && mask[K_AUTO]) begin
            if (m_state inside {StBanner, StEdit, StResult}) begin
                m_state = StAutoOps;
                m_aa = A0;
                m_ab = B0;
            end else if (m_state inside {StAutoOps, StAutoMul, StAutoProd}) begin
                m_state = StBanner;
            end
        end else if (mask[K_INC_A] || mask[K_INC_B]) begin
            if (m_state == StBanner) begin
                m_state = StEdit;
            end else if (m_state inside {StEdit, StResult}) begin
                m_a = m_a + W'(mask[K_INC_A]);
                m_b = m_b + W'(mask[K_INC_B]);
                m_state = StEdit;
            end
        end
        if (m_state != prev) m_cnt = 0;
    endtask

    task automatic model_tick();
        if (m_state == StAutoOps) begin
            m_cnt++;
            if (m_cnt == DWELL) begin
                m_aprod = mul(m_aa, m_ab);
                m_state = StAutoProd;
                m_cnt = 0;
            end
        end else if (m_state == StAutoProd) begin
            m_cnt++;
            if (m_cnt == DWELL) begin
                m_aa = m_aa + 1'b1;
                m_ab = m_ab + 1'b1;
                m_state = StAutoOps;
                m_cnt = 0;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".state"}, 64'(bus.state_o), 64'(m_state));
        check_eq({tag, ".disp"}, 64'(bus.disp_word), 64'(exp_disp()));
        check_eq({tag, ".led"}, 64'(bus.led_en), 64'(m_state == StBanner));
        check_eq({tag, ".busy"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic press(input logic [4:0] mask, input int settle, input bit chk,
                         input string tag);
        bus.key_n = ~mask;
        cyc(1);
        bus.key_n = '1;
        cyc(settle);
        model_press(mask);
        if (chk) check_all(tag);
    endtask

    task automatic tick_pulse(input string tag);
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        cyc(12);
        model_tick();
        check_all(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int res_at;
        int r;

        bus.key_n = '1;
        bus.tick  = 1'b0;
        rst = 1'b1;
        model_reset();
        cyc(2);
        check_all("rst");
        rst = 1'b0;
        cyc(1);
        check_all("rst_rel");

        // Mode press: no change one cycle after drive, BANNER after two.
        bus.key_n = ~KMode;
        cyc(1);
        bus.key_n = '1;
        check_eq("lat1", 64'(bus.state_o), 64'(StIdle));
        cyc(1);
        check_eq("lat2", 64'(bus.state_o), 64'(StBanner));
        model_press(KMode);
        check_all("banner");

        press(KIncA, 2, 1, "enter_edit");
        repeat (3) press(KIncA, 2, 1, "inc_a");
        repeat (2) press(KIncB, 2, 1, "inc_b");
        check_eq("edit_disp", 64'(bus.disp_word), 64'(24'h030200));

        repeat (12) press(KIncA, 2, 0, "");
        repeat (15) press(KIncB, 2, 0, "");
        check_eq("ops_0f11", 64'(bus.disp_word), 64'(24'h0F1100));

        // Multiply timing: CALC two cycles after drive, busy 8 cycles, RESULT at +9.
        bus.key_n = ~KEval;
        cyc(1);
        bus.key_n = '1;
        check_eq("eval_lat1", 64'(bus.state_o), 64'(StEdit));
        cyc(1);
        check_eq("eval_calc", 64'(bus.state_o), 64'(StCalc));
        busy_cnt = 0;
        res_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (res_at < 0 && bus.state_o === 3'(StResult)) res_at = i;
            cyc(1);
        end
        check_eq("busy_len", 64'(busy_cnt), 64'(8));
        check_eq("result_at", 64'(res_at), 64'(9));
        model_press(KEval);
        check_all("res_0f11");
        check_eq("res_disp", 64'(bus.disp_word), 64'(24'h0000FF));

        press(KIncA, 2, 1, "res_inc");
        repeat (8'hEF) press(KIncA, 2, 0, "");
        repeat (8'hEE) press(KIncB, 2, 0, "");
        check_all("ops_ffff");

        // Presses during CALC are ignored, including mode.
        bus.key_n = ~KEval;
        cyc(1);
        bus.key_n = '1;
        cyc(1);
        bus.key_n = ~(KMode | KIncA | KIncB);
        cyc(1);
        bus.key_n = '1;
        cyc(12);
        model_press(KEval);
        check_all("calc_ign");
        check_eq("ffff_prod", 64'(bus.disp_word), 64'(24'h00FE01));

        press(KIncA, 2, 1, "wrap");
        check_eq("wrap_disp", 64'(bus.disp_word), 64'(24'h00FF00));

        press(KMode | KIncA, 2, 1, "mode_pri");
        press(KMode, 2, 1, "to_banner");
        press(KIncA, 2, 1, "a_kept");

        press(KEval, 12, 1, "eval2");
        press(KAuto, 2, 1, "auto_ent");
`ifdef MCC_AUTO_EN
        check_eq("auto_ops1", 64'(bus.disp_word), 64'(24'h010200));
`endif
        tick_pulse("tick1");
`ifdef MCC_AUTO_EN
        check_eq("auto_prod1", 64'(bus.disp_word), 64'(24'h000002));
`endif
        tick_pulse("tick2");
`ifdef MCC_AUTO_EN
        check_eq("auto_ops2", 64'(bus.disp_word), 64'(24'h020300));
`endif
        tick_pulse("tick3");
`ifdef MCC_AUTO_EN
        check_eq("auto_prod2", 64'(bus.disp_word), 64'(24'h000006));
`endif
        press(KAuto, 2, 1, "auto_exit");

        // Key held through reset must not register as a press.
        bus.key_n = ~KMode;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        cyc(5);
        check_eq("held_rst", 64'(bus.state_o), 64'(StIdle));
        bus.key_n = '1;
        cyc(3);
        check_all("held_rel");

        // Reset in the middle of a multiply.
        press(KMode, 2, 1, "ab_banner");
        press(KIncA, 2, 0, "");
        press(KIncA, 2, 0, "");
        press(KIncB, 2, 1, "ab_edit");
        bus.key_n = ~KEval;
        cyc(1);
        bus.key_n = '1;
        cyc(3);
        check_eq("calc_busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        model_reset();
        check_eq("abort_state", 64'(bus.state_o), 64'(StIdle));
        check_eq("abort_busy", 64'(bus.busy), 64'(0));
        check_eq("abort_disp", 64'(bus.disp_word), 64'(0));
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.busy !== 1'b0 || bus.state_o !== 3'(StIdle)) busy_cnt++;
            cyc(1);
        end
        check_eq("abort_quiet", 64'(busy_cnt), 64'(0));

        // Random single-key / tick walk against the model.
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 6));
            case (r)
                0: press(KMode, 12, 1, "rnd_mode");
                1: press(KIncA, 12, 1, "rnd_inca");
                2: press(KIncB, 12, 1, "rnd_incb");
                3: press(KEval, 12, 1, "rnd_eval");
                4: press(KAuto, 12, 1, "rnd_auto");
                5: tick_pulse("rnd_tick");
                default: cyc(3);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
